uart_tx_buffer: RTL and testbench

Buffered UART transmit bridge between the CPU memory-mapped I/O decode and the `uart` transmitter core. CPU byte writes are queued in a FIFO without waiting on the serial line. A drain FSM feeds bytes to the UART one at a time using its `sendReq`/`ready` handshake. A status word exposes the FIFO level and flags so firmware can poll instead of spinning on the UART.

---
 rtl/uart_tx_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//
// Buffered transmit bridge between the CPU I/O decode and the UART transmitter.
// CPU byte writes go into a circular FIFO. A drain FSM hands the bytes to the
// UART one at a time over the tx_send / uart_ready handshake. A status register
// lets firmware poll the FIFO level and the drained flag.
//
// Configuration macro: UART_TX_BUFFER_STALL_EN
//   defined   : a data write to a full FIFO is held off (bus_ready withheld)
//               until there is room.
//   undefined : a data write to a full FIFO is acknowledged and discarded, and
//               an 8-bit saturating drop counter is bumped (status bits 31:24).
//
// Ports
//   clk          in   clock
//   resetn       in   synchronous active-low reset
//   bus_valid    in   CPU access request, held until bus_ready
//   bus_we       in   1 = write, 0 = read
//   bus_addr     in   0 = data register, 1 = status register
//   bus_wdata    in   byte to transmit
//   bus_rdata    out  read data, valid while bus_ready is high
//   bus_ready    out  one-cycle access-complete pulse
//   tx_data      out  byte presented to the UART (held until the next send)
//   tx_send      out  one-cycle send request to the UART
//   uart_ready   in   UART idle and able to take a byte
//
// Status word: bit0 empty, bit1 full, bit2 drained, [15:8] level,
//              [31:24] drop count (0 when stalling), all other bits 0.
// -----------------------------------------------------------------------------
module uart_tx_buffer #(
   parameter int DEPTH_LOG2   = 4,
   parameter int GUARD_CYCLES = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        bus_valid,
   input  logic        bus_we,
   input  logic        bus_addr,
   input  logic [7:0]  bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   input  logic        uart_ready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam int GW    = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES);
   localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES < 1) ? 0 : GUARD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;

   // Drain FSM
   state_t        state_q;
   state_t        state_d;
   logic [GW-1:0] guard_q;
   logic [GW-1:0] guard_d;
   logic [7:0]    tx_data_q;
   logic [7:0]    tx_data_d;
   logic          tx_send_q;
   logic          tx_send_d;
   logic          pop;

   // Bus side
   logic          bus_ready_q;
   logic [31:0]   bus_rdata_q;
   logic [31:0]   bus_rdata_d;
   logic          accept;
   logic          push;
   logic          is_data_wr;
   logic          empty;
   logic          full;
   logic          drained;
   logic [7:0]    drop_count;
   logic [31:0]   status_word;

   assign empty      = (level_q == '0);
   assign full       = (level_q == LW'(DEPTH));
   assign drained    = empty && (state_q == ST_IDLE) && uart_ready;
   assign is_data_wr = bus_we && !bus_addr;

`ifdef UART_TX_BUFFER_STALL_EN
   // A data write to a full FIFO is simply not accepted yet. Fullness is judged
   // on the registered level, so a pop in the same cycle never makes room.
   assign accept     = bus_valid && !bus_ready_q && !(is_data_wr && full);
   assign push       = accept && is_data_wr;
   assign drop_count = 8'h00;
`else
   logic [7:0] drop_q;

   assign accept     = bus_valid && !bus_ready_q;
   assign push       = accept && is_data_wr && !full;
   assign drop_count = drop_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         drop_q <= 8'h00;
      end else if (accept && is_data_wr && full && (drop_q != 8'hFF)) begin
         drop_q <= drop_q + 8'h01;
      end
   end
`endif

   // Status is sampled in the acceptance cycle from registered state, so it
   // reflects every push/pop that completed before that cycle.
   assign status_word = {drop_count, 8'h00, 8'(level_q), 5'b00000, drained, full, empty};

   always_comb begin
      bus_rdata_d = 32'h0000_0000;
      if (accept && !bus_we && bus_addr) begin
         bus_rdata_d = status_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus_ready_q <= 1'b0;
         bus_rdata_q <= 32'h0000_0000;
      end else begin
         bus_ready_q <= accept;
         bus_rdata_q <= bus_rdata_d;
      end
   end

   // FIFO storage has no reset; the pointers and level define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus_wdata;
      end
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         level_q <= level_d;
      end
   end

   // Drain FSM. IDLE issues the send and pops; ARM waits for the UART to take
   // the byte (uart_ready low), giving up after GUARD_CYCLES in case the UART
   // never visibly drops ready; BUSY waits for the UART to finish.
   always_comb begin
      state_d   = state_q;
      guard_d   = '0;
      tx_data_d = tx_data_q;
      tx_send_d = 1'b0;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty && uart_ready) begin
               tx_data_d = mem_q[rd_ptr_q];
               tx_send_d = 1'b1;
               pop       = 1'b1;
               state_d   = ST_ARM;
            end
         end
         ST_ARM: begin
            if (!uart_ready || (guard_q == GUARD_LAST)) begin
               state_d = ST_BUSY;
            end else begin
               guard_d = guard_q + GW'(1);
            end
         end
         ST_BUSY: begin
            if (uart_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         guard_q   <= '0;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         guard_q   <= guard_d;
         tx_data_q <= tx_data_d;
         tx_send_q <= tx_send_d;
      end
   end

   assign bus_ready = bus_ready_q;
   assign bus_rdata = bus_rdata_q;
   assign tx_data   = tx_data_q;
   assign tx_send   = tx_send_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffer
//
// Self-checking bench for uart_tx_buffer (default parameters). Bytes written
// by the CPU side are pushed into an expected-byte queue; every tx_send seen
// on the UART side is captured by a monitor and compared in order against it.
// A behavioural UART drives uart_ready: hold-low, never-drop, or realistic
// (ready falls one cycle after a send and rises ten cycles later).
// Build with +define+UART_TX_BUFFER_STALL_EN to check the stalling variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_buffer;

   localparam int GUARD = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        bus_valid;
   logic        bus_we;
   logic        bus_addr;
   logic [7:0]  bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic [7:0]  tx_data;
   logic        tx_send;
   logic        uart_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   uart_tx_buffer #(
      .DEPTH_LOG2   (4),
      .GUARD_CYCLES (GUARD)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus_valid  (bus_valid),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ready  (bus_ready),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .uart_ready (uart_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: captures each byte handed to the UART with its cycle stamp.
   logic [7:0] got_data [256];
   int         got_cyc  [256];
   int         got_n = 0;

   always @(negedge clk) begin
      if (tx_send === 1'b1 && got_n < 256) begin
         got_data[got_n] = tx_data;
         got_cyc[got_n]  = cyc;
         $display("[TB] send #%0d data=0x%02h cycle=%0d", got_n, tx_data, cyc);
         got_n = got_n + 1;
      end
   end

   // Behavioural UART.
   logic uart_hold_low = 1'b0;
   logic uart_no_drop  = 1'b0;
   logic u_pend        = 1'b0;
   int   u_cnt         = 0;

   always @(negedge clk) begin
      if (uart_hold_low) begin
         uart_ready = 1'b0;
         u_pend     = 1'b0;
         u_cnt      = 0;
      end else if (uart_no_drop) begin
         uart_ready = 1'b1;
      end else if (u_pend) begin
         uart_ready = 1'b0;
         u_cnt      = 10;
         u_pend     = 1'b0;
      end else if (u_cnt > 0) begin
         u_cnt = u_cnt - 1;
         if (u_cnt == 0) uart_ready = 1'b1;
      end else begin
         uart_ready = 1'b1;
      end
      if (tx_send === 1'b1 && !uart_hold_low && !uart_no_drop) u_pend = 1'b1;
   end

   // Scoreboard of bytes expected on the UART side, in order.
   logic [7:0] exp_q [$];
   int         got_rd = 0;

   // One bus access; the wait for bus_ready is bounded.
   task automatic do_access(input logic we, input logic addr, input logic [7:0] wd,
                            output logic [31:0] rd, output int t_start, output int t_ack);
      @(posedge clk); #1;
      bus_valid = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wd;
      t_start   = cyc;
      t_ack     = -1;
      rd        = 32'h0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus_ready === 1'b1) begin
            t_ack = cyc;
            rd    = bus_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      bus_valid = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 1'b0;
      bus_wdata = 8'h00;
      $display("[TB] access we=%0d addr=%0d wdata=0x%02h rdata=0x%08h start=%0d ack=%0d",
               we, addr, wd, rd, t_start, t_ack);
      if (t_ack < 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL bus_timeout: bus_ready not seen, required within 400 cycles");
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int ts, ta;
      resetn    = 1'b0;
      bus_valid = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 1'b0;
      bus_wdata = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus_ready !== 1'b0 || tx_send !== 1'b0 || bus_rdata !== 32'h0 || tx_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_outputs: ready=%b send=%b rdata=0x%08h txd=0x%02h, required all 0",
                  bus_ready, tx_send, bus_rdata, tx_data);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0000_0005) begin
         tests_failed++;
         $display("FAIL reset_status: got 0x%08h, required 0x00000005", rd);
      end
      tests_run++;
      if (got_n !== 0) begin
         tests_failed++;
         $display("FAIL reset_no_send: got %0d sends, required 0", got_n);
      end
   endtask

   task automatic test_regs();
      logic [31:0] rd;
      int ts, ta;
      do_access(1'b0, 1'b0, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0) begin
         tests_failed++;
         $display("FAIL data_read: got 0x%08h, required 0x00000000", rd);
      end
      do_access(1'b1, 1'b1, 8'hC3, rd, ts, ta);
      tests_run++;
      if (ta - ts !== 1) begin
         tests_failed++;
         $display("FAIL status_write_ack: latency %0d, required 1", ta - ts);
      end
      repeat (4) @(negedge clk);
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0000_0005 || got_n !== 0) begin
         tests_failed++;
         $display("FAIL status_write_ignored: status 0x%08h sends %0d, required 0x00000005 and 0", rd, got_n);
      end
   endtask

   task automatic test_single();
      logic [31:0] rd;
      logic [7:0]  e;
      int ts, ta, n0;
      n0 = got_n;
      exp_q.push_back(8'h41);
      do_access(1'b1, 1'b0, 8'h41, rd, ts, ta);
      tests_run++;
      if (ta - ts !== 1) begin
         tests_failed++;
         $display("FAIL single_ack_latency: got %0d, required 1", ta - ts);
      end
      for (int i = 0; i < 50 && got_n <= n0; i++) @(negedge clk);
      tests_run++;
      if (got_n !== n0 + 1) begin
         tests_failed++;
         $display("FAIL single_send_count: got %0d, required %0d", got_n - n0, 1);
      end else begin
         tests_run++;
         if (got_cyc[n0] - ts !== 2) begin
            tests_failed++;
            $display("FAIL single_send_latency: got %0d, required 2", got_cyc[n0] - ts);
         end
         e = exp_q.pop_front();
         tests_run++;
         if (got_data[n0] !== e) begin
            tests_failed++;
            $display("FAIL single_data: got 0x%02h, required 0x%02h", got_data[n0], e);
         end
         got_rd = got_n;
      end
      repeat (20) @(negedge clk);
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0000_0005) begin
         tests_failed++;
         $display("FAIL single_drained: got 0x%08h, required 0x00000005", rd);
      end
   endtask

   task automatic test_fill();
      logic [31:0] rd;
      logic [7:0]  e;
      int ts, ta, n0, min_gap;
      uart_hold_low = 1'b1;
      @(negedge clk);
      n0 = got_n;
      for (int b = 0; b < 16; b++) begin
         exp_q.push_back(8'(b));
         do_access(1'b1, 1'b0, 8'(b), rd, ts, ta);
      end
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0000_1002 || got_n !== n0) begin
         tests_failed++;
         $display("FAIL fill_status: got 0x%08h sends %0d, required 0x00001002 and 0", rd, got_n - n0);
      end
      uart_hold_low = 1'b0;
      for (int i = 0; i < 600 && got_n < n0 + 16; i++) @(negedge clk);
      tests_run++;
      if (got_n !== n0 + 16) begin
         tests_failed++;
         $display("FAIL fill_send_count: got %0d, required 16", got_n - n0);
      end
      min_gap = 1000;
      for (int i = got_rd; i < got_n; i++) begin
         if (i > n0 && got_cyc[i] - got_cyc[i-1] < min_gap) min_gap = got_cyc[i] - got_cyc[i-1];
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL fill_data: got 0x%02h, required no byte", got_data[i]);
         end else begin
            e = exp_q.pop_front();
            if (got_data[i] !== e) begin
               tests_failed++;
               $display("FAIL fill_data: got 0x%02h, required 0x%02h", got_data[i], e);
            end
         end
      end
      got_rd = got_n;
      tests_run++;
      if (min_gap < 3) begin
         tests_failed++;
         $display("FAIL fill_send_spacing: got %0d, required >= 3", min_gap);
      end
      repeat (20) @(negedge clk);
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0000_0005) begin
         tests_failed++;
         $display("FAIL fill_drained: got 0x%08h, required 0x00000005", rd);
      end
   endtask

   task automatic test_full_write();
      logic [31:0] rd;
      logic [31:0] exp_status;
      logic [7:0]  e;
      int ts, ta, n0, rel_cyc, n_exp;
      uart_hold_low = 1'b1;
      @(negedge clk);
      n0 = got_n;
      for (int b = 0; b < 16; b++) begin
         exp_q.push_back(8'(8'h20 + b));
         do_access(1'b1, 1'b0, 8'(8'h20 + b), rd, ts, ta);
      end
`ifdef UART_TX_BUFFER_STALL_EN
      exp_q.push_back(8'h99);
      n_exp      = 17;
      exp_status = 32'h0000_0005;
      rel_cyc    = 0;
      fork
         do_access(1'b1, 1'b0, 8'h99, rd, ts, ta);
         begin
            repeat (12) @(negedge clk);
            rel_cyc       = cyc;
            uart_hold_low = 1'b0;
         end
      join
      tests_run++;
      if (ta <= rel_cyc) begin
         tests_failed++;
         $display("FAIL stall_ack: ack cycle %0d, required after release cycle %0d", ta, rel_cyc);
      end
`else
      n_exp      = 16;
      exp_status = 32'h0100_0005;
      rel_cyc    = 0;
      do_access(1'b1, 1'b0, 8'h99, rd, ts, ta);
      tests_run++;
      if (ta - ts !== 1) begin
         tests_failed++;
         $display("FAIL drop_ack: latency %0d, required 1", ta - ts);
      end
      uart_hold_low = 1'b0;
`endif
      for (int i = 0; i < 700 && got_n < n0 + n_exp; i++) @(negedge clk);
      repeat (30) @(negedge clk);
      tests_run++;
      if (got_n !== n0 + n_exp) begin
         tests_failed++;
         $display("FAIL full_send_count: got %0d, required %0d", got_n - n0, n_exp);
      end
      for (int i = got_rd; i < got_n; i++) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL full_data: got 0x%02h, required no byte", got_data[i]);
         end else begin
            e = exp_q.pop_front();
            if (got_data[i] !== e) begin
               tests_failed++;
               $display("FAIL full_data: got 0x%02h, required 0x%02h", got_data[i], e);
            end
         end
      end
      got_rd = got_n;
      exp_q.delete();
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== exp_status) begin
         tests_failed++;
         $display("FAIL full_status: got 0x%08h, required 0x%08h", rd, exp_status);
      end
   endtask

   task automatic test_guard();
      logic [31:0] rd;
      logic [31:0] exp_status;
      logic [7:0]  e;
      int ts, ta, n0;
      uart_no_drop = 1'b1;
      @(negedge clk);
      n0 = got_n;
      exp_q.push_back(8'h5A);
      do_access(1'b1, 1'b0, 8'h5A, rd, ts, ta);
      exp_q.push_back(8'hA5);
      do_access(1'b1, 1'b0, 8'hA5, rd, ts, ta);
      for (int i = 0; i < 60 && got_n < n0 + 2; i++) @(negedge clk);
      tests_run++;
      if (got_n !== n0 + 2) begin
         tests_failed++;
         $display("FAIL guard_send_count: got %0d, required 2", got_n - n0);
      end else begin
         tests_run++;
         if (got_cyc[n0+1] - got_cyc[n0] !== GUARD + 2) begin
            tests_failed++;
            $display("FAIL guard_spacing: got %0d, required %0d", got_cyc[n0+1] - got_cyc[n0], GUARD + 2);
         end
      end
      for (int i = got_rd; i < got_n; i++) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL guard_data: got 0x%02h, required no byte", got_data[i]);
         end else begin
            e = exp_q.pop_front();
            if (got_data[i] !== e) begin
               tests_failed++;
               $display("FAIL guard_data: got 0x%02h, required 0x%02h", got_data[i], e);
            end
         end
      end
      got_rd = got_n;
      repeat (10) @(negedge clk);
`ifdef UART_TX_BUFFER_STALL_EN
      exp_status = 32'h0000_0005;
`else
      exp_status = 32'h0100_0005;
`endif
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== exp_status) begin
         tests_failed++;
         $display("FAIL guard_status: got 0x%08h, required 0x%08h", rd, exp_status);
      end
      uart_no_drop = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int ts, ta, n0;
      uart_hold_low = 1'b1;
      @(negedge clk);
      n0 = got_n;
      for (int b = 0; b < 5; b++) begin
         do_access(1'b1, 1'b0, 8'(8'h60 + b), rd, ts, ta);
      end
      @(posedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      uart_hold_low = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      exp_q.delete();
      repeat (30) @(negedge clk);
      tests_run++;
      if (got_n !== n0) begin
         tests_failed++;
         $display("FAIL reset_mid_no_send: got %0d sends, required 0", got_n - n0);
      end
      do_access(1'b0, 1'b1, 8'h00, rd, ts, ta);
      tests_run++;
      if (rd !== 32'h0000_0005) begin
         tests_failed++;
         $display("FAIL reset_mid_status: got 0x%08h, required 0x00000005", rd);
      end
      got_rd = got_n;
   endtask

   initial begin
      test_reset();
      test_regs();
      test_single();
      test_fill();
      test_full_write();
      test_guard();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
